// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and helpers for the fetch instruction queue.
// Defaults here size the queue, its interface and the lane compactor.
package fetch_inst_queue_pkg;

    localparam int SIZE_PC          = 64;
    localparam int SIZE_INSTRUCTION = 32;
    localparam int DEF_FETCH_WIDTH  = 4;
    localparam int DEF_DECODE_WIDTH = 4;
    localparam int DEF_DEPTH        = 16;

    typedef struct packed {
        logic [SIZE_PC-1:0]          pc;
        logic [SIZE_INSTRUCTION-1:0] inst;
        logic                        exc;
    } fetchQEntry_t;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// slave is the queue itself, master is whoever drives fetch and decode.
interface fetch_inst_queue_if
    import fetch_inst_queue_pkg::*;
#(
    parameter int FW = DEF_FETCH_WIDTH,
    parameter int DW = DEF_DECODE_WIDTH
) ();

    logic                                  fetchValid_i;
    logic [SIZE_PC-1:0]                    fetchPC_i;
    logic [FW-1:0][SIZE_INSTRUCTION-1:0]   inst_i;
    logic [FW-1:0]                         instValid_i;
    logic                                  instExc_i;
    logic                                  fetchReady_o;

    logic [DW-1:0][SIZE_INSTRUCTION-1:0]   decInst_o;
    logic [DW-1:0][SIZE_PC-1:0]            decPC_o;
    logic [DW-1:0]                         decExc_o;
    logic [DW-1:0]                         decValid_o;
    logic                                  decReady_i;

    modport slave (
        input  fetchValid_i, fetchPC_i, inst_i,
        input  instValid_i, instExc_i, decReady_i,
        output fetchReady_o, decInst_o, decPC_o,
        output decExc_o, decValid_o
    );

    modport master (
        output fetchValid_i, fetchPC_i, inst_i,
        output instValid_i, instExc_i, decReady_i,
        input  fetchReady_o, decInst_o, decPC_o,
        input  decExc_o, decValid_o
    );

endinterface

// File: rtl/fetch_inst_queue_lane_compact.sv
// Packs the valid lanes of a fetch bundle into consecutive entries.
// An excepting bundle collapses to a single marker entry at lane 0's PC.
module fetch_lane_compact
    import fetch_inst_queue_pkg::*;
#(
    parameter int FW = DEF_FETCH_WIDTH,
    parameter int CW = $clog2(FW + 1)
) (
    input  logic [SIZE_PC-1:0]                pc_i,
    input  logic [FW-1:0][SIZE_INSTRUCTION-1:0] inst_i,
    input  logic [FW-1:0]                     valid_i,
    input  logic                              exc_i,
    output fetchQEntry_t [FW-1:0]             entry_o,
    output logic [CW-1:0]                     nEnq_o
);

    localparam int IW = (FW > 1) ? $clog2(FW) : 1;

    logic [CW-1:0] slot;

    always_comb begin
        entry_o = '0;
        nEnq_o  = '0;
        slot    = '0;
        if (exc_i) begin
            entry_o[0].pc  = pc_i;
            entry_o[0].exc = 1'b1;
            nEnq_o         = CW'(1);
        end else begin
            // slot is the running prefix sum of valid lanes below k
            for (int k = 0; k < FW; k++) begin
                if (valid_i[k]) begin
                    entry_o[slot[IW-1:0]].pc   = pc_i + SIZE_PC'(4 * k);
                    entry_o[slot[IW-1:0]].inst = inst_i[k];
                    slot = slot + CW'(1);
                end
            end
            nEnq_o = CW'(popcount(32'(valid_i)));
        end
    end

endmodule

// File: rtl/fetch_inst_queue.sv
// Decoupling queue between the I-cache stage and decode.
// Circular entry buffer; fullness is tracked by count, not pointers.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int FETCH_WIDTH  = DEF_FETCH_WIDTH,
    parameter int DECODE_WIDTH = DEF_DECODE_WIDTH,
    parameter int DEPTH        = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    fetch_inst_queue_if.slave            fq_if,
    output logic [$clog2(DEPTH):0]       occupancy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(FETCH_WIDTH + 1);
    localparam logic [PW:0] READY_MAX = (PW+1)'(DEPTH - FETCH_WIDTH);
    localparam logic [PW:0] DW_CNT    = (PW+1)'(DECODE_WIDTH);

    fetchQEntry_t mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    fetchQEntry_t [FETCH_WIDTH-1:0] cEntry;
    logic [CW-1:0] nEnq;
    logic [PW:0]   nDeq;
    logic          ready;
    logic          enq;
    logic          deq;

    fetch_lane_compact #(.FW(FETCH_WIDTH), .CW(CW)) u_compact (
        .pc_i    (fq_if.fetchPC_i),
        .inst_i  (fq_if.inst_i),
        .valid_i (fq_if.instValid_i),
        .exc_i   (fq_if.instExc_i),
        .entry_o (cEntry),
        .nEnq_o  (nEnq)
    );

    assign ready = (count_q <= READY_MAX);
    assign enq   = fq_if.fetchValid_i & ready & ~flush_i;
    assign deq   = fq_if.decReady_i & ~flush_i;
    assign nDeq  = (count_q < DW_CNT) ? count_q : DW_CNT;

    assign fq_if.fetchReady_o = ready;
    assign occupancy_o        = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d  = tail_q + PW'(nEnq);
                count_d = count_d + (PW+1)'(nEnq);
            end
            if (deq) begin
                head_d  = head_q + nDeq[PW-1:0];
                count_d = count_d - nDeq;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; decValid_o gates its use.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (CW'(i) < nEnq) begin
                    mem_q[tail_q + PW'(i)] <= cEntry[i];
                end
            end
        end
    end

    always_comb begin
        fq_if.decInst_o  = '0;
        fq_if.decPC_o    = '0;
        fq_if.decExc_o   = '0;
        fq_if.decValid_o = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            fq_if.decInst_o[k]  = mem_q[head_q + PW'(k)].inst;
            fq_if.decPC_o[k]    = mem_q[head_q + PW'(k)].pc;
            fq_if.decExc_o[k]   = mem_q[head_q + PW'(k)].exc;
            fq_if.decValid_o[k] = (count_q > (PW+1)'(k));
        end
    end

    a_count_bound : assert property (
        @(posedge clk) disable iff (!reset)
        count_q <= (PW+1)'(DEPTH)
    );

    a_no_enq_full : assert property (
        @(posedge clk) disable iff (!reset)
        enq |-> ready
    );

endmodule
